// File: rtl/codec_config_sequencer_pkg.sv
// codec_cfg_pkg: shared types and constants for the codec configuration sequencer.
//   cfg_state_e     sequencer FSM state encoding
//   CODEC_DEV_ADDR  codec I2C write address (first byte of every transaction)
//   CODEC_NUM_REGS  number of entries in the power-up register table
//   cfg_word(idx)   power-up table: {reg_addr[6:0], reg_data[8:0]} per entry
package codec_cfg_pkg;

  localparam logic [7:0] CODEC_DEV_ADDR = 8'h34;
  localparam int         CODEC_NUM_REGS = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  // Codec reset (R15) goes first and the activate register (R9) goes last,
  // so the datapath only starts once every other register is settled.
  function automatic logic [15:0] cfg_word(input int unsigned idx);
    case (idx)
      0:       return 16'h1E00;
      1:       return 16'h0017;
      2:       return 16'h0217;
      3:       return 16'h0479;
      4:       return 16'h0679;
      5:       return 16'h0812;
      6:       return 16'h0A00;
      7:       return 16'h0C00;
      8:       return 16'h0E01;
      9:       return 16'h1000;
      10:      return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/codec_config_sequencer_if.sv
// codec_config_sequencer_if: handshake between the sequencer and the I2C byte-writer.
//   i2c_start  1-cycle request pulse (sequencer -> writer)
//   i2c_data   24-bit word {dev_addr, reg_addr, reg_data}, stable during i2c_start
//   i2c_done   writer idle/finished level (writer -> sequencer)
//   i2c_ack    all three bytes ACKed, valid while i2c_done=1
// master = sequencer side, slave = writer side.
interface codec_config_sequencer_if;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (output i2c_start, output i2c_data, input i2c_done, input i2c_ack);
  modport slave  (input i2c_start, input i2c_data, output i2c_done, output i2c_ack);
endinterface

// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks the codec power-up register table after reset,
// issuing one 24-bit I2C write per entry, retrying NACKed entries, then reports
// completion or error to the audio datapath.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   go            1-cycle pulse, reruns the table; honoured only in DONE/ERROR
//   bus           writer handshake (master modport): i2c_start/i2c_data out, i2c_done/i2c_ack in
//   busy          high from leaving IDLE until entering DONE/ERROR
//   config_done   level, whole table ACKed
//   config_err    level, an entry ran out of retries
//   err_index     failing table index (4'hF for a runtime write), 0 otherwise
// Optional macro CODEC_RUNTIME_WRITE_EN adds wr_req/wr_word/wr_ack: single
// register writes accepted while in DONE.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS    = CODEC_NUM_REGS,
  parameter logic [7:0] DEV_ADDR    = CODEC_DEV_ADDR,
  parameter int         MAX_RETRIES = 3,
  parameter int         GAP_CYCLES  = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     go,
  codec_config_sequencer_if.master bus,
  output logic                     busy,
  output logic                     config_done,
  output logic                     config_err,
  output logic [3:0]               err_index
`ifdef CODEC_RUNTIME_WRITE_EN
  ,
  input  logic                     wr_req,
  input  logic [15:0]              wr_word,
  output logic                     wr_ack
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  cfg_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [RTY_W-1:0] retry_q;
  logic [GAP_W-1:0] gap_q;
  logic [23:0]      data_q;
  logic [3:0]       err_q;
  logic             done_q, errf_q;
  logic             rt_q;         // current transaction is a runtime write, not a table entry
  logic [15:0]      rt_word_q;
  logic             go_take, wr_take;
  logic             wr_req_i;
  logic [15:0]      wr_word_i;

`ifdef CODEC_RUNTIME_WRITE_EN
  assign wr_req_i  = wr_req;
  assign wr_word_i = wr_word;
`else
  assign wr_req_i  = 1'b0;
  assign wr_word_i = 16'h0000;
`endif

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    go_take = 1'b0;
    wr_take = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ARM;
      ST_ARM:   state_d = ST_WAIT;   // done may still be high from the previous transfer
      ST_WAIT:  if (bus.i2c_done) state_d = ST_CHECK;
      ST_CHECK: begin
        if (bus.i2c_ack)
          state_d = (rt_q || idx_q == LAST_IDX) ? ST_DONE : ST_GAP;
        else if (retry_q < RTY_MAX)
          state_d = ST_GAP;
        else
          state_d = ST_ERROR;
      end
      ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_LOAD;
      ST_DONE: begin
        if (go) begin
          go_take = 1'b1;
          state_d = ST_LOAD;
        end else if (wr_req_i) begin
          wr_take = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_ERROR: begin
        if (go) begin
          go_take = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- state + datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      errf_q    <= 1'b0;
      rt_q      <= 1'b0;
      rt_word_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD:  data_q <= {DEV_ADDR, rt_q ? rt_word_q : cfg_word(32'(idx_q))};
        ST_CHECK: begin
          if (bus.i2c_ack) begin
            retry_q <= '0;
            if (rt_q)
              rt_q <= 1'b0;
            else if (idx_q == LAST_IDX)
              done_q <= 1'b1;
            else
              idx_q <= idx_q + 1'b1;
          end else if (retry_q < RTY_MAX) begin
            retry_q <= retry_q + 1'b1;
          end else begin
            err_q  <= rt_q ? 4'hF : 4'(idx_q);
            errf_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_GAP:   gap_q <= (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
        default:  ;
      endcase
      if (go_take) begin
        done_q  <= 1'b0;
        errf_q  <= 1'b0;
        err_q   <= '0;
        idx_q   <= '0;
        retry_q <= '0;
        rt_q    <= 1'b0;
      end
      if (wr_take) begin
        rt_q      <= 1'b1;
        rt_word_q <= wr_word_i;
      end
    end
  end

`ifdef CODEC_RUNTIME_WRITE_EN
  // Registered so the pulse lines up with the first cycle back in DONE.
  logic wr_ack_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_ack_q <= 1'b0;
    else          wr_ack_q <= (state_q == ST_CHECK) && rt_q && bus.i2c_ack;
  end
  assign wr_ack = wr_ack_q;
`endif

  assign bus.i2c_start = (state_q == ST_ISSUE);
  assign bus.i2c_data  = data_q;
  assign busy          = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign config_done   = done_q;
  assign config_err    = errf_q;
  assign err_index     = err_q;

endmodule
